disk_track_loader: RTL and testbench

Moves one Disk II nibble track (13 × 512-byte SD sectors, 6656 bytes) between the mounted SD image and the core's track RAM. It sits between `hps_io` (SD sector interface) and `apple2_top` (`TRACK`, `TRACK_RAM_*`, `CPU_WAIT`). It reloads whenever the head moves to a new track or a new image is mounted. With write-back compiled in, it first flushes a dirty track to the image.

---
 rtl/disk_pkg.sv | 16 +
 rtl/disk_track_loader.sv | 178 +++++++++++++++++
 tb/tb_disk_track_loader.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/disk_pkg.sv
// Shared constants, FSM encoding and track-to-LBA mapping for the Disk II track loader.
package disk_pkg;

  localparam int SECTORS_PER_TRACK = 13;
  localparam int TRACK_BYTES       = 6656;

  typedef enum logic [1:0] {IDLE, FLUSH, LOAD} dtl_state_t;

  // 13*T built from shifts; 63*13 = 819 fits easily in 10 bits.
  function automatic logic [31:0] track_lba(input logic [5:0] t);
    logic [9:0] tt;
    tt = {4'd0, t};
    return {22'd0, (tt << 3) + (tt << 2) + tt};
  endfunction

endpackage

// File: rtl/disk_track_loader.sv
// Disk II track loader: moves one 13-sector nibble track between the SD image and track RAM.
// Latency: request 1 cycle after the trigger; each sd_ack edge answered 1 cycle later.
// Backpressure: holds cpu_wait across a transfer; DISK_WRITEBACK_EN adds dirty-track flush.
module disk_track_loader
  import disk_pkg::*;
#(
  parameter int SECTORS = SECTORS_PER_TRACK
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [5:0]  track,
  input  logic        track_dirty,
  input  logic        img_mounted,
  input  logic [63:0] img_size,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  output logic [12:0] track_ram_addr,
  input  logic [7:0]  track_ram_dout,
  output logic [7:0]  sd_buff_din,
  output logic        cpu_wait,
  output logic        busy
);

  dtl_state_t  state, state_nxt;
  logic [5:0]  cur_track, cur_track_nxt;
  logic        valid, valid_nxt;
  logic        mnt_pend, mnt_pend_nxt;
  logic [3:0]  track_sec, track_sec_nxt;
  logic [31:0] sd_lba_nxt;
  logic        sd_rd_nxt;
  logic        cpu_wait_nxt;
  logic        ack_q;

  logic        ack_rise, ack_fall, last_sec, track_moved, img_present;

`ifdef DISK_WRITEBACK_EN
  logic        dirty, dirty_nxt;
  logic        wr_q, wr_nxt;
`endif

  assign ack_rise    = sd_ack & ~ack_q;
  assign ack_fall    = ~sd_ack & ack_q;
  assign last_sec    = (track_sec == 4'(SECTORS - 1));
  assign track_moved = (track != cur_track);
  assign img_present = (img_size != 64'd0);

  assign track_ram_addr = {track_sec, sd_buff_addr};
  assign busy           = (state != IDLE);

`ifdef DISK_WRITEBACK_EN
  assign sd_wr       = wr_q;
  assign sd_buff_din = track_ram_dout;
`else
  assign sd_wr       = 1'b0;
  assign sd_buff_din = 8'd0;
  logic unused_wb;
  assign unused_wb = ^{track_dirty, track_ram_dout};
`endif

  always_comb begin
    state_nxt     = state;
    cur_track_nxt = cur_track;
    valid_nxt     = valid;
    mnt_pend_nxt  = mnt_pend | img_mounted;
    track_sec_nxt = track_sec;
    sd_lba_nxt    = sd_lba;
    sd_rd_nxt     = sd_rd;
    cpu_wait_nxt  = cpu_wait;
`ifdef DISK_WRITEBACK_EN
    dirty_nxt     = dirty;
    wr_nxt        = wr_q;
`endif

    case (state)
      IDLE: begin
`ifdef DISK_WRITEBACK_EN
        if (track_dirty) dirty_nxt = 1'b1;
`endif
        if (mnt_pend) begin
          // A mount arriving in this very cycle stays pending.
          mnt_pend_nxt = img_mounted;
          valid_nxt    = 1'b0;
`ifdef DISK_WRITEBACK_EN
          dirty_nxt    = 1'b0;
        end else if (dirty && valid && track_moved) begin
          state_nxt     = FLUSH;
          track_sec_nxt = 4'd0;
          sd_lba_nxt    = track_lba(cur_track);
          wr_nxt        = 1'b1;
          cpu_wait_nxt  = 1'b1;
`endif
        end else if (img_present && (!valid || track_moved)) begin
          state_nxt     = LOAD;
          cur_track_nxt = track;
          track_sec_nxt = 4'd0;
          sd_lba_nxt    = track_lba(track);
          sd_rd_nxt     = 1'b1;
          cpu_wait_nxt  = 1'b1;
        end
      end

`ifdef DISK_WRITEBACK_EN
      FLUSH: begin
        if (track_dirty) dirty_nxt = 1'b1;
        if (ack_rise) begin
          sd_lba_nxt = sd_lba + 32'd1;
          if (last_sec) wr_nxt = 1'b0;
        end
        if (ack_fall) begin
          track_sec_nxt = track_sec + 4'd1;
          if (!wr_q) begin
            // Old track is on the image; reload straight away without releasing the core.
            dirty_nxt     = track_dirty;
            state_nxt     = LOAD;
            cur_track_nxt = track;
            track_sec_nxt = 4'd0;
            sd_lba_nxt    = track_lba(track);
            sd_rd_nxt     = 1'b1;
          end
        end
      end
`endif

      LOAD: begin
        if (ack_rise) begin
          sd_lba_nxt = sd_lba + 32'd1;
          if (last_sec) sd_rd_nxt = 1'b0;
        end
        if (ack_fall) begin
          track_sec_nxt = track_sec + 4'd1;
          if (!sd_rd) begin
            valid_nxt    = 1'b1;
            cpu_wait_nxt = 1'b0;
            state_nxt    = IDLE;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= IDLE;
      cur_track <= 6'd0;
      valid     <= 1'b0;
      mnt_pend  <= 1'b0;
      track_sec <= 4'd0;
      sd_lba    <= 32'd0;
      sd_rd     <= 1'b0;
      cpu_wait  <= 1'b0;
      ack_q     <= 1'b0;
`ifdef DISK_WRITEBACK_EN
      dirty     <= 1'b0;
      wr_q      <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      cur_track <= cur_track_nxt;
      valid     <= valid_nxt;
      mnt_pend  <= mnt_pend_nxt;
      track_sec <= track_sec_nxt;
      sd_lba    <= sd_lba_nxt;
      sd_rd     <= sd_rd_nxt;
      cpu_wait  <= cpu_wait_nxt;
      ack_q     <= sd_ack;
`ifdef DISK_WRITEBACK_EN
      dirty     <= dirty_nxt;
      wr_q      <= wr_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_disk_track_loader.sv
// Bench for disk_track_loader: directed track table, corner sequences, then random events vs a track-level model.
`timescale 1ns/1ps
module tb_disk_track_loader;

`ifdef DISK_WRITEBACK_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif
  localparam logic [63:0] IMG_BYTES = 64'd143360;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [5:0]  track;
  logic        track_dirty;
  logic        img_mounted;
  logic [63:0] img_size;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [12:0] track_ram_addr;
  logic [7:0]  track_ram_dout;
  logic [7:0]  sd_buff_din;
  logic        cpu_wait;
  logic        busy;

  logic [7:0]  ram [0:8191];
  int          checks = 0;
  int          failures = 0;

  // Track-level model: which track the RAM holds and whether it is usable / modified.
  int          m_cur;
  bit          m_valid, m_dirty, m_pend;

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) track_ram_dout <= ram[track_ram_addr];

  disk_track_loader dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .track          (track),
    .track_dirty    (track_dirty),
    .img_mounted    (img_mounted),
    .img_size       (img_size),
    .sd_lba         (sd_lba),
    .sd_rd          (sd_rd),
    .sd_wr          (sd_wr),
    .sd_ack         (sd_ack),
    .sd_buff_addr   (sd_buff_addr),
    .track_ram_addr (track_ram_addr),
    .track_ram_dout (track_ram_dout),
    .sd_buff_din    (sd_buff_din),
    .cpu_wait       (cpu_wait),
    .busy           (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Behaves like hps_io for one 13-sector transfer; optional one-shot injection at a sector start.
  // inj_kind: 0 none, 1 track change to inj_val, 2 track_dirty pulse, 3 img_mounted pulse.
  task automatic serve(input bit wr, input int lba0, input int inj_sec, input int inj_kind, input int inj_val);
    int          n;
    int          len;
    logic [3:0]  s4;
    logic [12:0] prev;
    bit          have_prev;
    n = 0;
    while (!(sd_rd || sd_wr) && n < 40) begin
      tick();
      n++;
    end
    chk("req_seen", sd_rd | sd_wr, 1);
    if (!(sd_rd || sd_wr)) return;
    chk("req_is_wr", sd_wr, wr);
    chk("req_is_rd", sd_rd, !wr);
    chk("cpu_wait_hi", cpu_wait, 1);
    chk("busy_hi", busy, 1);
    for (int s = 0; s < 13; s++) begin
      s4 = 4'(s);
      repeat ($urandom_range(0, 2)) tick();
      chk("sec_lba", sd_lba, lba0 + s);
      chk("req_hold", wr ? sd_wr : sd_rd, 1);
      len = $urandom_range(2, 4);
      have_prev = 1'b0;
      for (int k = 0; k < len; k++) begin
        sd_ack = 1'b1;
        sd_buff_addr = 9'($urandom);
        if (s == inj_sec && k == 0) begin
          case (inj_kind)
            1: track = 6'(inj_val);
            2: track_dirty = 1'b1;
            3: img_mounted = 1'b1;
            default: ;
          endcase
        end
        #2;
        chk("ram_addr", track_ram_addr, {s4, sd_buff_addr});
        if (have_prev) chk("buff_din", sd_buff_din, WB ? ram[prev] : 8'd0);
        prev = {s4, sd_buff_addr};
        have_prev = 1'b1;
        tick();
        track_dirty = 1'b0;
        img_mounted = 1'b0;
        if (k == 0) begin
          chk("lba_step", sd_lba, lba0 + s + 1);
          chk("req_after_ack", wr ? sd_wr : sd_rd, s != 12);
        end
      end
      sd_ack = 1'b0;
      tick();
    end
    // A finished flush hands over to a load in the same cycle; a finished load releases the core.
    chk("cpu_wait_end", cpu_wait, wr);
    chk("busy_end", busy, wr);
  endtask

  task automatic quiet(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick();
      chk("quiet_rd", sd_rd, 0);
      chk("quiet_wr", sd_wr, 0);
      chk("quiet_wait", cpu_wait, 0);
    end
  endtask

  task automatic model_xfer(input bit wr, input int trk);
    int sec, kind, val;
    sec  = $urandom_range(0, 12);
    kind = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
    val  = $urandom_range(0, 63);
    serve(wr, 13 * trk, sec, kind, val);
    if (kind == 2 && wr) m_dirty = 1'b1;
    if (kind == 3) m_pend = 1'b1;
  endtask

  // Runs every transfer the model expects from the current idle situation, then confirms silence.
  task automatic settle();
    for (int i = 0; i < 12; i++) begin
      if (m_pend) begin
        m_pend = 1'b0;
        m_valid = 1'b0;
        m_dirty = 1'b0;
      end
      if (m_dirty && m_valid && int'(track) != m_cur) begin
        m_dirty = 1'b0;
        model_xfer(1'b1, m_cur);
        m_cur = int'(track);
        model_xfer(1'b0, m_cur);
        m_valid = 1'b1;
      end else if (img_size != 64'd0 && (!m_valid || int'(track) != m_cur)) begin
        m_cur = int'(track);
        model_xfer(1'b0, m_cur);
        m_valid = 1'b1;
      end else begin
        break;
      end
    end
    quiet(4);
  endtask

  typedef struct {
    int trk;
    int lba;
  } vec_t;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [6];
    vecs[0] = '{trk: 17, lba: 221};
    vecs[1] = '{trk: 5,  lba: 65};
    vecs[2] = '{trk: 34, lba: 442};
    vecs[3] = '{trk: 63, lba: 819};
    vecs[4] = '{trk: 1,  lba: 13};
    vecs[5] = '{trk: 0,  lba: 0};

    for (int i = 0; i < 8192; i++) ram[i] = 8'($urandom);
    reset = 1'b1;
    track = 6'd0;
    track_dirty = 1'b0;
    img_mounted = 1'b0;
    img_size = IMG_BYTES;
    sd_ack = 1'b0;
    sd_buff_addr = 9'd0;
    repeat (3) tick();
    chk("rst_lba", sd_lba, 0);
    chk("rst_rd", sd_rd, 0);
    chk("rst_wr", sd_wr, 0);
    chk("rst_wait", cpu_wait, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ram_addr", track_ram_addr, 0);

    reset = 1'b0;
    tick();
    chk("first_req_latency", sd_rd, 1);
    serve(1'b0, 0, 13, 0, 0);

    for (int i = 0; i < 6; i++) begin
      track = 6'(vecs[i].trk);
      tick();
      chk("tbl_req", sd_rd, 1);
      chk("tbl_lba", sd_lba, vecs[i].lba);
      serve(1'b0, vecs[i].lba, 13, 0, 0);
    end

    // Dirty track 3, then step to 4.
    track = 6'd3;
    serve(1'b0, 39, 13, 0, 0);
    track_dirty = 1'b1;
    tick();
    track_dirty = 1'b0;
    track = 6'd4;
`ifdef DISK_WRITEBACK_EN
    serve(1'b1, 39, 13, 0, 0);
`endif
    serve(1'b0, 52, 13, 0, 0);
    quiet(3);

    // Mount during sector 5: finish, then reload the same track once.
    track = 6'd9;
    serve(1'b0, 117, 5, 3, 0);
    serve(1'b0, 117, 13, 0, 0);
    quiet(4);

    // Head moves 5 -> 6 at sector 8: finish 5, then load 6 without a flush.
    track = 6'd5;
    serve(1'b0, 65, 8, 1, 6);
    serve(1'b0, 78, 13, 0, 0);
    quiet(3);

    // No image: head movement must not start anything.
    img_mounted = 1'b1;
    tick();
    img_mounted = 1'b0;
    img_size = 64'd0;
    quiet(3);
    track = 6'd20;
    quiet(6);
    track = 6'd41;
    quiet(4);

    img_mounted = 1'b1;
    tick();
    img_mounted = 1'b0;
    img_size = IMG_BYTES;
    serve(1'b0, 533, 13, 0, 0);

    // Reset in the middle of a load: requests drop, contents invalidated, track reloads.
    track = 6'd30;
    tick();
    chk("mid_req", sd_rd, 1);
    sd_ack = 1'b1;
    tick();
    sd_ack = 1'b0;
    tick();
    chk("mid_lba", sd_lba, 391);
    reset = 1'b1;
    tick();
    chk("mid_rst_rd", sd_rd, 0);
    chk("mid_rst_wait", cpu_wait, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_lba", sd_lba, 0);
    reset = 1'b0;
    serve(1'b0, 390, 13, 0, 0);
    quiet(2);

    m_cur = 30;
    m_valid = 1'b1;
    m_dirty = 1'b0;
    m_pend = 1'b0;
    for (int e = 0; e < 40; e++) begin
      case ($urandom_range(0, 3))
        0, 1: track = 6'($urandom_range(0, 63));
        2: begin
          track_dirty = 1'b1;
          tick();
          track_dirty = 1'b0;
          if (WB) m_dirty = 1'b1;
        end
        default: begin
          img_mounted = 1'b1;
          tick();
          img_mounted = 1'b0;
          img_size = ($urandom_range(0, 3) == 0) ? 64'd0 : IMG_BYTES;
          m_pend = 1'b1;
        end
      endcase
      settle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
